// File: rtl/serial_alu_seq_pkg.sv
// rtl/serial_alu_seq_pkg.sv - shared opcode/state constants and carry helper for serial_alu_seq
package serial_alu_seq_pkg;

   // Opcode encoding {op2,op1}; op2 selects arithmetic, op1 selects OR/SUB.
   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_SUB = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_FINISH = 2'b10
   } state_e;

   // Full-adder carry: majority of three bits.
   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

endpackage

// File: rtl/mux1bit4to1.sv
// rtl/mux1bit4to1.sv - 1-bit 4:1 mux selected by {op2,op1}
module mux1bit4to1 (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   input  logic d_i,
   input  logic op1_i,
   input  logic op2_i,
   output logic y_o
);

   // Select a/b/c/d for {op2,op1} = 00/01/10/11.
   always_comb begin
      y_o = a_i;
      case ({op2_i, op1_i})
         2'b00:   y_o = a_i;
         2'b01:   y_o = b_i;
         2'b10:   y_o = c_i;
         default: y_o = d_i;
      endcase
   end

endmodule

// File: rtl/serial_alu_seq.sv
// rtl/serial_alu_seq.sv - bit-serial AND/OR/ADD/SUB unit; SERIAL_ALU_OVF_EN adds the overflow output
module serial_alu_seq
   import serial_alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       opcode,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
`ifdef SERIAL_ALU_OVF_EN
   output logic             overflow,
`endif
   output logic             zero
);

   localparam int            CW       = $clog2(WIDTH + 1);
   // Counter value once every bit has been processed; that RUN cycle publishes the result.
   localparam logic [CW-1:0] LAST     = CW'(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [1:0]       op_q, op_d;
   logic             cy_q, cy_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
`ifdef SERIAL_ALU_OVF_EN
   logic             msb_cy_q, msb_cy_d;
   logic             ovf_q, ovf_d;
`endif

   logic bit_a, bit_b, b_eff, cy_next, sel_bit, arith;

   assign bit_a   = a_q[0];
   assign bit_b   = b_q[0];
   // SUB adds the inverted subtrahend; op1 distinguishes SUB from ADD.
   assign b_eff   = bit_b ^ op_q[0];
   assign cy_next = maj3(bit_a, b_eff, cy_q);
   assign arith   = op_q[1];

   mux1bit4to1 u_mux (
      .a_i   (bit_a & bit_b),
      .b_i   (bit_a | bit_b),
      .c_i   (bit_a ^ bit_b ^ cy_q),
      .d_i   (bit_a ^ ~bit_b ^ cy_q),
      .op1_i (op_q[0]),
      .op2_i (op_q[1]),
      .y_o   (sel_bit)
   );

   // Next-state and datapath update: load on accepted start, shift per bit, publish at the end.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      cy_d     = cy_q;
      sh_d     = sh_q;
      result_d = result_q;
      carry_d  = carry_q;
      zero_d   = zero_q;
`ifdef SERIAL_ALU_OVF_EN
      msb_cy_d = msb_cy_q;
      ovf_d    = ovf_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               a_d     = opa;
               b_d     = opb;
               op_d    = opcode;
               cy_d    = (opcode == OP_SUB);
               sh_d    = '0;
            end
         end
         ST_RUN: begin
            if (cnt_q == LAST) begin
               state_d  = ST_FINISH;
               result_d = sh_q;
               zero_d   = (sh_q == '0);
               carry_d  = arith & cy_q;
`ifdef SERIAL_ALU_OVF_EN
               ovf_d    = arith & (msb_cy_q ^ cy_q);
`endif
            end else begin
               sh_d  = {sel_bit, sh_q[WIDTH-1:1]};
               a_d   = a_q >> 1;
               b_d   = b_q >> 1;
               cy_d  = cy_next;
               cnt_d = cnt_q + CW'(1);
`ifdef SERIAL_ALU_OVF_EN
               // Remember the carry into the MSB for the signed-overflow test.
               if (cnt_q == LAST_BIT) begin
                  msb_cy_d = cy_q;
               end
`endif
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         cy_q     <= 1'b0;
         sh_q     <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
         msb_cy_q <= 1'b0;
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         cy_q     <= cy_d;
         sh_q     <= sh_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
`ifdef SERIAL_ALU_OVF_EN
         msb_cy_q <= msb_cy_d;
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_FINISH);
   assign result    = result_q;
   assign carry_out = carry_q;
   assign zero      = zero_q;
`ifdef SERIAL_ALU_OVF_EN
   assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_alu_seq.sv
// tb/tb_serial_alu_seq.sv - self-checking bench for serial_alu_seq (WIDTH=8), SERIAL_ALU_OVF_EN aware
module tb_serial_alu_seq;

   localparam int W   = 8;
   localparam int LAT = W + 1;

   typedef struct {
      logic [W-1:0] r;
      logic         c;
      logic         z;
      logic         v;
   } exp_t;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      exp_t         e;
      string        name;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   opcode = 2'b00;
   logic [W-1:0] opa = '0;
   logic [W-1:0] opb = '0;
   logic         busy, done, carry_out, zero;
   logic [W-1:0] result;
`ifdef SERIAL_ALU_OVF_EN
   logic         overflow;
`endif

   int   errors = 0;
   int   checks = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   serial_alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .opcode    (opcode),
      .opa       (opa),
      .opb       (opb),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
`ifdef SERIAL_ALU_OVF_EN
      .overflow  (overflow),
`endif
      .zero      (zero)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference arithmetic on whole words, independent of the serial datapath.
   function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t        e;
      logic [W:0]  s;
      e.c = 1'b0;
      e.v = 1'b0;
      case (op)
         2'b00: e.r = a & b;
         2'b01: e.r = a | b;
         2'b10: begin
            s   = {1'b0, a} + {1'b0, b};
            e.r = s[W-1:0];
            e.c = s[W];
            e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
         end
         default: begin
            s   = {1'b0, a} - {1'b0, b};
            e.r = s[W-1:0];
            e.c = (a >= b);
            e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
         end
      endcase
      e.z = (e.r == '0);
      return e;
   endfunction

   // Issue one operation from an IDLE negedge, optionally pulse a second start mid-run,
   // then compare the popped expectation when done appears and check the pulse width.
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input exp_t e, input int inject, input string name);
      int   lat;
      bit   seen;
      exp_t x;
      sb_q.push_back(e);
      start  = 1'b1;
      opcode = op;
      opa    = a;
      opb    = b;
      @(posedge clk);
      #1 start = 1'b0;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 4 * LAT) begin
         if (inject != 0 && lat == inject) begin
            start  = 1'b1;
            opcode = 2'b11;
            opa    = 8'hAA;
            opb    = 8'h01;
         end
         @(posedge clk);
         #1 start = 1'b0;
         lat++;
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (sb_q.size() == 0) begin
         chk({name, " scoreboard empty"}, 32'd1, 32'd0);
      end else begin
         x = sb_q.pop_front();
         if (!seen) begin
            chk({name, " done timeout"}, 32'd0, 32'd1);
         end else begin
            chk({name, " latency"}, lat, LAT);
            chk({name, " busy in finish"}, busy, 1'b1);
            chk({name, " result"}, result, x.r);
            chk({name, " carry_out"}, carry_out, x.c);
            chk({name, " zero"}, zero, x.z);
`ifdef SERIAL_ALU_OVF_EN
            chk({name, " overflow"}, overflow, x.v);
`endif
            @(negedge clk);
            chk({name, " done one cycle"}, done, 1'b0);
            chk({name, " idle after"}, busy, 1'b0);
         end
      end
   endtask

   initial begin
      vec_t vecs[9];
      exp_t e;
      int   pulses;

      vecs[0] = '{2'b10, 8'h7F, 8'h01, '{8'h80, 1'b0, 1'b0, 1'b1}, "add_7f_01"};
      vecs[1] = '{2'b11, 8'h05, 8'h05, '{8'h00, 1'b1, 1'b1, 1'b0}, "sub_05_05"};
      vecs[2] = '{2'b11, 8'h03, 8'h05, '{8'hFE, 1'b0, 1'b0, 1'b0}, "sub_03_05"};
      vecs[3] = '{2'b00, 8'hF0, 8'h3C, '{8'h30, 1'b0, 1'b0, 1'b0}, "and_f0_3c"};
      vecs[4] = '{2'b01, 8'hF0, 8'h0F, '{8'hFF, 1'b0, 1'b0, 1'b0}, "or_f0_0f"};
      vecs[5] = '{2'b10, 8'hFF, 8'h01, '{8'h00, 1'b1, 1'b1, 1'b0}, "add_ff_01"};
      vecs[6] = '{2'b11, 8'h80, 8'h01, '{8'h7F, 1'b1, 1'b0, 1'b1}, "sub_80_01"};
      vecs[7] = '{2'b10, 8'h80, 8'h80, '{8'h00, 1'b1, 1'b1, 1'b1}, "add_80_80"};
      vecs[8] = '{2'b00, 8'hF0, 8'h0F, '{8'h00, 1'b0, 1'b1, 1'b0}, "and_zero"};

      // Reset state, observed while rst_n is held low.
      #1;
      chk("reset busy", busy, 1'b0);
      chk("reset done", done, 1'b0);
      chk("reset result", result, 8'h00);
      chk("reset carry_out", carry_out, 1'b0);
      chk("reset zero", zero, 1'b0);
`ifdef SERIAL_ALU_OVF_EN
      chk("reset overflow", overflow, 1'b0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Table vectors, issued back-to-back (start in the cycle after done).
      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e, 0, vecs[i].name);
      end

      // Random operands against the word-level model.
      for (int i = 0; i < 8; i++) begin
         logic [1:0]   op;
         logic [W-1:0] a, b;
         op = 2'($urandom_range(0, 3));
         a  = 8'($urandom);
         b  = 8'($urandom);
         e  = model(op, a, b);
         run_op(op, a, b, e, 0, "random");
      end

      // Start pulsed three cycles into RUN with other operands must be ignored.
      e = model(2'b10, 8'h12, 8'h34);
      run_op(2'b10, 8'h12, 8'h34, e, 3, "ignored_start");
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("ignored_start extra done", pulses, 0);
      chk("ignored_start result held", result, 8'h46);

      // Reset asserted at RUN cycle 4 aborts without a done pulse.
      start  = 1'b1;
      opcode = 2'b10;
      opa    = 8'h55;
      opb    = 8'h22;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("midrun busy before reset", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("midrun reset busy", busy, 1'b0);
      chk("midrun reset done", done, 1'b0);
      chk("midrun reset result", result, 8'h00);
      chk("midrun reset carry_out", carry_out, 1'b0);
      chk("midrun reset zero", zero, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      chk("midrun no done", pulses, 0);
      run_op(2'b10, 8'hFF, 8'h01, '{8'h00, 1'b1, 1'b1, 1'b0}, 0, "after_reset_add");

      chk("scoreboard drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
